// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: nibble-serial add/subtract sequencer built around one 4-bit carry-lookahead slice
module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] op_a, op_b;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [3:0]      na, nb, g, p, nsum;
    logic [4:0]      c;
    logic            last, accept;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = idx == IW'(N - 1);
    assign busy   = state == RUN;
    assign done   = state == DONE;

    // Current nibble through the carry-lookahead equations
    always_comb begin
        na   = op_a[idx*4 +: 4];
        nb   = op_b[idx*4 +: 4];
        g    = na & nb;
        p    = na ^ nb;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nsum = p ^ c[3:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state: start only matters outside RUN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on accept, then one nibble per clock with the carry chained in a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub | c_in;
            idx      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == RUN) begin
            sum[idx*4 +: 4] <= nsum;
            carry           <= c[4];
            idx             <= idx + 1'b1;
            if (last) begin
                c_out    <= c[4];
                overflow <= c[3] ^ c[4];
            end
        end
    end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb_cla_serial_add_ctrl: randomized and directed checks of the serial CLA adder against an arithmetic model
module tb_cla_serial_add_ctrl;
  localparam int W = 16;
  localparam int N = W / 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out, overflow;
  logic [W-1:0] sum;
  int errors = 0;
  int checks = 0;
  cla_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         ov;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + (s ? (W+1)'(1) : (W+1)'(ci));
    ov = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    input logic ts, output int lat, output int bc);
    @(negedge clk);
    a = ta; b = tb; c_in = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
  endtask
  task automatic test_reset;
    int seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_during: got busy=%b done=%b sum=%h co=%b ov=%b expected all 0", busy, done, sum, c_out, overflow);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if ({busy, done, sum, c_out, overflow} !== '0 || seen != 0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b sum=%h seen=%0d expected all 0", busy, done, sum, seen);
    end
  endtask
  task automatic test_add;
    int lat, bc;
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL add_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (sum[3:0] !== 4'h3) begin
      errors++;
      $display("FAIL add_nibble0: got %h expected 3", sum[3:0]);
    end
    lat = 1;
    bc = 1 + (busy ? 1 : 0);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
    checks++;
    if (lat != N || bc != N) begin
      errors++;
      $display("FAIL add_timing: got lat=%0d busy=%0d expected %0d %0d", lat, bc, N, N);
    end
    checks++;
    if (sum !== 16'h2233 || c_out !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_result: got sum=%h co=%b ov=%b busy=%b expected 2233 0 0 0", sum, c_out, overflow, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h2233) begin
      errors++;
      $display("FAIL add_hold: got done=%b busy=%b sum=%h expected 0 0 2233", done, busy, sum);
    end
  endtask
  task automatic test_carry_chain;
    int lat, bc;
    op(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat, bc);
    checks++;
    if ({overflow, c_out, sum} !== {1'b0, 1'b1, 16'h0001} || lat != N) begin
      errors++;
      $display("FAIL carry_wrap: got sum=%h co=%b ov=%b lat=%0d expected 0001 1 0 %0d", sum, c_out, overflow, lat, N);
    end
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    checks++;
    if ({overflow, c_out, sum} !== {1'b1, 1'b0, 16'h8000} || lat != N) begin
      errors++;
      $display("FAIL carry_ovf: got sum=%h co=%b ov=%b lat=%0d expected 8000 0 1 %0d", sum, c_out, overflow, lat, N);
    end
  endtask
  task automatic test_subtract;
    int lat, bc;
    op(16'h8000, 16'h0001, 1'b1, 1'b1, lat, bc);
    checks++;
    if ({overflow, c_out, sum} !== {1'b1, 1'b1, 16'h7FFF}) begin
      errors++;
      $display("FAIL sub_ovf: got sum=%h co=%b ov=%b expected 7fff 1 1", sum, c_out, overflow);
    end
    op(16'h0003, 16'h0005, 1'b0, 1'b1, lat, bc);
    checks++;
    if ({overflow, c_out, sum} !== {1'b0, 1'b0, 16'hFFFE}) begin
      errors++;
      $display("FAIL sub_borrow: got sum=%h co=%b ov=%b expected fffe 0 0", sum, c_out, overflow);
    end
  endtask
  task automatic test_handshake;
    logic [W-1:0] x, y;
    logic [W+1:0] e;
    int lat;
    x = W'($urandom); y = W'($urandom);
    e = model(x, y, 1'b0, 1'b0);
    @(negedge clk);
    a = x; b = y; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = ~x; b = W'($urandom); c_in = 1'b1; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({overflow, c_out, sum} !== e || lat != N) begin
      errors++;
      $display("FAIL handshake: got %h lat=%0d expected %h lat=%0d", {overflow, c_out, sum}, lat, e, N);
    end
  endtask
  task automatic test_back_to_back;
    logic [W-1:0] xs[5], ys[5];
    logic         ss[5];
    logic [W+1:0] e;
    int cnt;
    for (int i = 0; i < 5; i++) begin
      xs[i] = W'($urandom); ys[i] = W'($urandom); ss[i] = 1'($urandom);
    end
    @(negedge clk);
    a = xs[0]; b = ys[0]; sub = ss[0]; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = xs[1]; b = ys[1]; sub = ss[1];
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (!done && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      e = model(xs[k], ys[k], 1'b0, ss[k]);
      checks++;
      if ({overflow, c_out, sum} !== e || cnt != N || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d: got %h cnt=%0d busy=%b expected %h cnt=%0d", k, {overflow, c_out, sum}, cnt, busy, e, N);
      end
      if (k == 3) begin
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_restart_%0d: got busy=%b done=%b expected 1 0", k, busy, done);
        end
        a = xs[k+2]; b = ys[k+2]; sub = ss[k+2];
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask
  task automatic test_reset_mid_op;
    int lat, bc, seen;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got busy=%b done=%b sum=%h co=%b ov=%b expected all 0", busy, done, sum, c_out, overflow);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0 || sum !== '0) begin
      errors++;
      $display("FAIL midrst_quiet: got seen=%0d sum=%h expected 0 0000", seen, sum);
    end
    op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bc);
    checks++;
    if (sum !== 16'h0100 || c_out !== 1'b0 || lat != N) begin
      errors++;
      $display("FAIL midrst_after: got sum=%h co=%b lat=%0d expected 0100 0 %0d", sum, c_out, lat, N);
    end
  endtask
  task automatic test_random;
    logic [W-1:0] x, y;
    logic         ci, s;
    logic [W+1:0] e;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom); s = 1'($urandom);
      if (i == 0) begin x = 16'hFFFF; y = 16'hFFFF; end
      if (i == 1) begin x = 16'h8000; y = 16'h8000; end
      e = model(x, y, ci, s);
      op(x, y, ci, s, lat, bc);
      checks++;
      if ({overflow, c_out, sum} !== e || lat != N || bc != N) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h ci=%b sub=%b got %h lat=%0d busy=%0d expected %h %0d %0d",
                 i, x, y, ci, s, {overflow, c_out, sum}, lat, bc, e, N, N);
      end
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_carry_chain;
    test_subtract;
    test_handshake;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
